// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared types and defaults for the hazard scoreboard
package hazard_scoreboard_pkg;

    localparam int MULT_LAT_DEFAULT = 10;
    localparam int REG_IDX_W        = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic {
        RF_INT = 1'b0,
        RF_FP  = 1'b1
    } rf_sel_e;

endpackage

// File: rtl/hazard_scoreboard_mult_busy_ctr.sv
// rtl/hazard_scoreboard_mult_busy_ctr.sv - multiplier occupancy down-counter
module mult_busy_ctr
    import hazard_scoreboard_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic busy,
    output logic done
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = 4'(MULT_LAT);
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != 4'd0);
    assign done = (cnt_q == 4'd1);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - RAW/WAW/structural issue scoreboard for long-latency producers
// Optional: SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback satisfy a RAW source.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEFAULT,
    parameter int NREG     = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           issue_valid,
    input  reg_idx_t       issue_rd,
    input  logic           issue_rd_fp,
    input  logic           issue_load,
    input  logic           issue_mult,
    input  reg_idx_t       src_a,
    input  reg_idx_t       src_b,
    input  logic           use_a,
    input  logic           use_b,
    input  logic           src_a_fp,
    input  logic           src_b_fp,
    input  logic           wb_valid,
    input  reg_idx_t       wb_rd,
    input  logic           wb_fp,
    output logic           stall,
    output logic           issue_ack,
    output logic           mult_busy,
    output logic           mult_done,
    output logic [6:0]     pend_cnt
);

    logic [NREG-1:0] pend_int_q, pend_int_d;
    logic [NREG-1:0] pend_fp_q,  pend_fp_d;
    logic [6:0]      pend_cnt_q, pend_cnt_d;

    logic long_lat, set_en;
    logic a_pend, b_pend, dst_pend, dst_clr;
    logic byp_a, byp_b;
    logic raw, waw, structural;

    assign long_lat = issue_load || issue_mult;
    assign a_pend   = (rf_sel_e'(src_a_fp) == RF_FP) ? pend_fp_q[src_a] : pend_int_q[src_a];
    assign b_pend   = (rf_sel_e'(src_b_fp) == RF_FP) ? pend_fp_q[src_b] : pend_int_q[src_b];
    assign dst_pend = (rf_sel_e'(issue_rd_fp) == RF_FP) ? pend_fp_q[issue_rd] : pend_int_q[issue_rd];

    // A destination retiring this cycle is no WAW hazard: the new set wins over the clear.
    assign dst_clr  = wb_valid && (wb_rd == issue_rd) && (wb_fp == issue_rd_fp);

`ifdef SCOREBOARD_WB_BYPASS_EN
    assign byp_a = wb_valid && (wb_rd == src_a) && (wb_fp == src_a_fp);
    assign byp_b = wb_valid && (wb_rd == src_b) && (wb_fp == src_b_fp);
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif

    assign raw        = (use_a && a_pend && !byp_a) || (use_b && b_pend && !byp_b);
    assign waw        = long_lat && dst_pend && !dst_clr;
    assign structural = issue_mult && mult_busy && !mult_done;

    assign stall     = issue_valid && (raw || waw || structural);
    assign issue_ack = issue_valid && !stall;
    assign set_en    = issue_ack && long_lat;

    mult_busy_ctr #(
        .MULT_LAT (MULT_LAT)
    ) u_mult_busy_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (issue_ack && issue_mult),
        .busy  (mult_busy),
        .done  (mult_done)
    );

    always_comb begin
        pend_int_d = pend_int_q;
        pend_fp_d  = pend_fp_q;
        if (wb_valid) begin
            if (rf_sel_e'(wb_fp) == RF_FP) pend_fp_d[wb_rd]  = 1'b0;
            else                           pend_int_d[wb_rd] = 1'b0;
        end
        if (set_en) begin
            if (rf_sel_e'(issue_rd_fp) == RF_FP) pend_fp_d[issue_rd] = 1'b1;
            else if (issue_rd != '0)             pend_int_d[issue_rd] = 1'b1;
        end
        pend_cnt_d = 7'($countones(pend_int_d)) + 7'($countones(pend_fp_d));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_int_q <= '0;
            pend_fp_q  <= '0;
            pend_cnt_q <= 7'd0;
        end else begin
            pend_int_q <= pend_int_d;
            pend_fp_q  <= pend_fp_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid, issue_rd_fp, issue_load, issue_mult;
    logic [4:0] issue_rd, src_a, src_b, wb_rd;
    logic       use_a, use_b, src_a_fp, src_b_fp, wb_valid, wb_fp;
    logic       stall, issue_ack, mult_busy, mult_done;
    logic [6:0] pend_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_rd_fp (issue_rd_fp),
        .issue_load  (issue_load),
        .issue_mult  (issue_mult),
        .src_a       (src_a),
        .src_b       (src_b),
        .use_a       (use_a),
        .use_b       (use_b),
        .src_a_fp    (src_a_fp),
        .src_b_fp    (src_b_fp),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_fp       (wb_fp),
        .stall       (stall),
        .issue_ack   (issue_ack),
        .mult_busy   (mult_busy),
        .mult_done   (mult_done),
        .pend_cnt    (pend_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        issue_valid = 0; issue_rd = 0; issue_rd_fp = 0; issue_load = 0; issue_mult = 0;
        src_a = 0; src_b = 0; use_a = 0; use_b = 0; src_a_fp = 0; src_b_fp = 0;
        wb_valid = 0; wb_rd = 0; wb_fp = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic fp, input logic ld, input logic ml);
        idle();
        issue_valid = 1; issue_rd = rd; issue_rd_fp = fp; issue_load = ld; issue_mult = ml;
    endtask

    task automatic reader(input logic [4:0] ra, input logic fa);
        idle();
        issue_valid = 1; issue_rd = 5'd10; use_a = 1; src_a = ra; src_a_fp = fa;
    endtask

    task automatic wb(input logic [4:0] rd, input logic fp);
        wb_valid = 1; wb_rd = rd; wb_fp = fp;
    endtask

    initial begin
        rst_n = 0;
        idle();
        #12;
        chk("rst_stall", stall, 0);
        chk("rst_busy", mult_busy, 0);
        chk("rst_done", mult_done, 0);
        chk("rst_pend_cnt", pend_cnt, 0);
        rst_n = 1;
        step();

        // Load r5 then RAW reader
        issue(5, 0, 1, 0); #1;
        chk("ld_r5_ack", issue_ack, 1);
        step();
        reader(5, 0); #1;
        chk("raw_r5_pend_cnt", pend_cnt, 1);
        for (int i = 0; i < 3; i++) begin
            chk("raw_r5_stall", stall, 1);
            step();
        end
        wb(5, 0); #1;
        chk("raw_r5_wb_ack", issue_ack, BYP);
        step();
        wb_valid = 0; #1;
        chk("raw_r5_after_ack", issue_ack, 1);
        chk("raw_r5_after_cnt", pend_cnt, 0);
        step();

        // Back-to-back multiplies
        issue(3, 1, 0, 1); #1;
        chk("mul1_ack", issue_ack, 1);
        step();
        issue(4, 1, 0, 1); #1;
        for (int i = 1; i <= 9; i++) begin
            chk("mul2_stall", stall, 1);
            chk("mul2_busy", mult_busy, 1);
            chk("mul2_done", mult_done, 0);
            step();
        end
        chk("mul2_done_cycle", mult_done, 1);
        chk("mul2_ack", issue_ack, 1);
        chk("mul2_busy_done", mult_busy, 1);
        step();
        idle(); #1;
        chk("mul2_reload_busy", mult_busy, 1);
        chk("mul2_done_clear", mult_done, 0);
        chk("mul_pend_cnt", pend_cnt, 2);
        wb(3, 1); step();
        idle(); wb(4, 1); step();
        idle(); #1;
        chk("mul_wb_cnt", pend_cnt, 0);

        // r0 never pending
        issue(0, 0, 1, 0); step();
        reader(0, 0); #1;
        chk("r0_stall", stall, 0);
        chk("r0_pend_cnt", pend_cnt, 0);
        step();

        // Independent files
        issue(7, 0, 1, 0); step();
        reader(7, 1); use_b = 1; src_b = 7; src_b_fp = 1; #1;
        chk("fp7_stall", stall, 0);
        chk("r7_pend_cnt", pend_cnt, 1);
        src_b_fp = 0; #1;
        chk("int7_stall", stall, 1);
        idle(); wb(7, 0); step();
        idle(); #1;
        chk("r7_clear_cnt", pend_cnt, 0);

        // Same-cycle writeback and reissue to r9
        issue(9, 0, 1, 0); step();
        issue(9, 0, 1, 0); #1;
        chk("waw_r9_stall", stall, 1);
        wb(9, 0); #1;
        chk("wb_set_r9_ack", issue_ack, 1);
        step();
        reader(9, 0); #1;
        chk("wb_set_r9_cnt", pend_cnt, 1);
        chk("wb_set_r9_still", stall, 1);
        idle(); wb(9, 0); step();
        idle(); wb(12, 0); step();
        idle(); #1;
        chk("wb_unpend_cnt", pend_cnt, 0);

        // Async reset mid-multiply
        for (int i = 0; i < 20 && mult_busy; i++) step();
        chk("drain_busy", mult_busy, 0);
        issue(1, 1, 0, 1); step();
        issue(1, 0, 1, 0); step();
        issue(2, 0, 1, 0); step();
        issue(3, 0, 1, 0); step();
        reader(1, 0); #1;
        chk("pre_rst_cnt", pend_cnt, 4);
        chk("pre_rst_busy", mult_busy, 1);
        chk("pre_rst_stall", stall, 1);
        #1 rst_n = 0;
        #1;
        chk("arst_cnt", pend_cnt, 0);
        chk("arst_busy", mult_busy, 0);
        chk("arst_done", mult_done, 0);
        chk("arst_stall", stall, 0);
        @(negedge clk);
        rst_n = 1;
        issue(5, 0, 1, 0);
        step();
        idle(); #1;
        chk("post_rst_cnt", pend_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have parameter MULT_LAT, default 10, giving the multiply latency in cycles (legal range 2..15).
REQ-002 The block SHALL have parameter NREG, default 32, giving the number of registers per file.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port issue_valid, input, 1 bit: an instruction in decode requests issue.
REQ-006 Port issue_rd / issue_rd_fp, input, 5/1 bits: destination register and its file (1 = FP).
REQ-007 Port issue_load / issue_mult, input, 1/1 bits: the instruction is a load or a multiply, i.e. a long-latency producer.
REQ-008 Port src_a / src_b, input, 5/5 bits: source registers.
REQ-009 Port use_a / use_b, input, 1/1 bits: the corresponding source is actually read.
REQ-010 Port src_a_fp / src_b_fp, input, 1/1 bits: the file each source is read from.
REQ-011 Port wb_valid / wb_rd / wb_fp, input, 1/5/1 bits: a long-latency result is being written back this cycle.
REQ-012 Port stall, output, 1 bit, combinational: hold the fetch and decode registers and insert a nop into execute.
REQ-013 Port issue_ack, output, 1 bit: equals issue_valid && !stall.
REQ-014 Port mult_busy / mult_done, output, 1/1 bits: the multiplier is occupied / the multiplier completes this cycle (one-cycle pulse).
REQ-015 Port pend_cnt, output, 7 bits: number of pending bits currently set across both files.

Function
REQ-016 The block SHALL hold two NREG-bit pending vectors, one for the integer file and one for the FP file.
REQ-017 On issue_ack with issue_load or issue_mult, the block SHALL set the pending bit for issue_rd in the file selected by issue_rd_fp.
REQ-018 Integer register 0 SHALL never be set pending; FP register 0 SHALL be treated as a normal register.
REQ-019 On wb_valid, the block SHALL clear the pending bit for wb_rd in the file selected by wb_fp.
REQ-020 If a set and a clear target the same bit in the same cycle, the set SHALL win.
REQ-021 stall SHALL be 1 when issue_valid and any of the following holds:
- a used source has its pending bit set (RAW);
- the destination of a long-latency producer is already pending (WAW);
- issue_mult while mult_busy is 1 and mult_done is 0 (structural).
REQ-022 ALU-only results SHALL never set pending bits; they are covered by forwarding outside this block.
REQ-023 The multiply counter SHALL be 4 bits and load MULT_LAT on issue_ack with issue_mult.
REQ-024 While the counter is nonzero and not reloading, it SHALL decrement by 1 each cycle.
REQ-025 mult_busy SHALL equal (counter != 0).
REQ-026 mult_done SHALL be 1 exactly in the cycle in which the counter equals 1.
REQ-027 A new multiply SHALL be accepted in its mult_done cycle, reloading the counter with no idle cycle between multiplies.
REQ-028 pend_cnt SHALL be registered and track the set bits of both vectors after each edge; the counter cannot overflow, since the maximum is 2*NREG-1.
REQ-029 wb_valid for a bit that is not pending SHALL be ignored without error.

Reset
REQ-030 While rst_n is 0, independent of clk, the block SHALL clear both pending vectors, the multiply counter and pend_cnt, and drive mult_busy = 0 and mult_done = 0.
REQ-031 stall SHALL be 0 during reset.
REQ-032 On the first edge after reset release, the block SHALL accept an issue normally.

Configuration
REQ-033 With SCOREBOARD_WB_BYPASS_EN defined, a source matching the same-cycle wb_valid/wb_rd/wb_fp SHALL NOT cause a RAW stall.
REQ-034 Without SCOREBOARD_WB_BYPASS_EN, such a source SHALL stall for that cycle and issue on the next cycle.

Structure
REQ-035 A shared package SHALL hold the register-index typedef, the file-select encoding (INT = 0, FP = 1) and MULT_LAT_DEFAULT = 10.
REQ-036 The multiply counter SHALL be a sub-module named mult_busy_ctr with ports clk, rst_n, load, busy and done.

Verification
REQ-037 The bench SHALL cover these directed scenarios:
- Load to integer r5, then issue an instruction with use_a and src_a = 5: stall = 1 until wb_valid with wb_rd = 5; with the macro, issue_ack in the writeback cycle; without it, issue_ack one cycle later.
- Multiply to FP f3, then a second multiply on the next cycle: stall is held for 9 cycles; the second multiply is acked on the mult_done cycle (cycle 10); mult_busy stays 1 continuously.
- Load to integer r0, then a reader of r0: no stall; pend_cnt stays 0.
- Load to integer r7 and a read of FP f7: no stall (files are independent).
- Same-cycle wb of r9 and issue of a load to r9: the r9 pending bit remains 1; pend_cnt is unchanged.
- Assert rst_n = 0 mid-multiply with 4 bits pending: pend_cnt = 0, mult_busy = 0 and stall = 0 immediately, without waiting for a clock edge.
